// File: rtl/demux4b_1to4_tdm.sv
// Receive-side TDM de-interleaver: collects four WIDTH-bit slot words (a,b,c,d)
// and publishes a complete frame on out_a..out_d with a one-cycle frame_valid pulse.
module demux4b_1to4_tdm #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [1:0]       slot
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow_q [3];
  logic [WIDTH-1:0] shadow_d [3];
  logic [WIDTH-1:0] out_a_d, out_b_d, out_c_d, out_d_d;
  logic             frame_valid_d, sync_err_d;
  logic             accept;

  assign accept = enable & din_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      shadow_q    <= '{default: '0};
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_d       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      out_a       <= out_a_d;
      out_b       <= out_b_d;
      out_c       <= out_c_d;
      out_d       <= out_d_d;
      frame_valid <= frame_valid_d;
      sync_err    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    out_a_d       = out_a;
    out_b_d       = out_b;
    out_c_d       = out_c;
    out_d_d       = out_d;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (accept) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            slot_d      = 2'd1;
            state_d     = LOCK;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            // A sync in slot 1..3 restarts the frame; the partial frame is dropped.
            sync_err_d  = (slot_q != 2'd0);
            shadow_d[0] = din;
            slot_d      = 2'd1;
          end else begin
            case (slot_q)
              2'd0: shadow_d[0] = din;
              2'd1: shadow_d[1] = din;
              2'd2: shadow_d[2] = din;
              default: begin
                out_a_d       = shadow_q[0];
                out_b_d       = shadow_q[1];
                out_c_d       = shadow_q[2];
                out_d_d       = din;
                frame_valid_d = 1'b1;
              end
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign locked = (state_q == LOCK);
  assign slot   = slot_q;

endmodule

// File: tb/tb_demux4b_1to4_tdm.sv
// Scoreboard bench for demux4b_1to4_tdm: expected frames are queued as the
// slot-3 word is driven and compared whenever frame_valid pulses.
module tb_demux4b_1to4_tdm;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         frame_valid, sync_err, locked;
  logic [1:0]   slot;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int serr_cnt = 0;
  logic [4*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  demux4b_1to4_tdm #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked), .slot(slot)
  );

  // Output monitor: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sync_err) serr_cnt++;
      if (frame_valid) begin
        logic [4*W-1:0] e;
        fv_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected got=%h expected=none", {out_a, out_b, out_c, out_d});
        end else begin
          e = exp_q.pop_front();
          if ({out_a, out_b, out_c, out_d} !== e) begin
            failures++;
            $display("FAIL frame_data got=%h expected=%h", {out_a, out_b, out_c, out_d}, e);
          end
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] w, input logic s, input logic v, input logic e);
    din = w; frame_sync = s; din_valid = v; enable = e;
    @(posedge clk); #1;
    din_valid = 1'b0; frame_sync = 1'b0; enable = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_power_on;
    #1;
    checks++;
    if ({out_a, out_b, out_c, out_d} !== '0) begin
      failures++; $display("FAIL por_outs got=%h expected=0", {out_a, out_b, out_c, out_d});
    end
    checks++;
    if ({frame_valid, sync_err, locked, slot} !== 5'b0) begin
      failures++; $display("FAIL por_flags got=%b expected=00000", {frame_valid, sync_err, locked, slot});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int fv0;
    fv0 = fv_cnt;
    drive(4'h1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({locked, slot} !== 3'b101) begin
      failures++; $display("FAIL nom_lock got=%b expected=101", {locked, slot});
    end
    drive(4'h2, 1'b0, 1'b1, 1'b1);
    drive(4'h4, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(16'h1248);
    drive(4'h8, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({frame_valid, out_a, out_b, out_c, out_d} !== {1'b1, 16'h1248}) begin
      failures++; $display("FAIL nom_latency got=%h expected=11248", {frame_valid, out_a, out_b, out_c, out_d});
    end
    drive(4'h2, 1'b0, 1'b1, 1'b1);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++; $display("FAIL nom_pulse_width got=%b expected=0", frame_valid);
    end
    drive(4'h3, 1'b0, 1'b1, 1'b1);
    drive(4'h5, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({frame_valid, out_a, out_b, out_c, out_d} !== {1'b0, 16'h1248}) begin
      failures++; $display("FAIL nom_hold got=%h expected=01248", {frame_valid, out_a, out_b, out_c, out_d});
    end
    exp_q.push_back(16'h235E);
    drive(4'hE, 1'b0, 1'b1, 1'b1);
    checks++;
    if (frame_valid !== 1'b1) begin
      failures++; $display("FAIL nom_second_pulse got=%b expected=1", frame_valid);
    end
    idle(2);
    checks++;
    if (fv_cnt - fv0 !== 2) begin
      failures++; $display("FAIL nom_pulse_count got=%0d expected=2", fv_cnt - fv0);
    end
  endtask

  task automatic test_reset;
    drive(4'h6, 1'b1, 1'b1, 1'b1);
    drive(4'h7, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_a, out_b, out_c, out_d, frame_valid, sync_err, locked, slot} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h/%b expected=0/00000", {out_a, out_b, out_c, out_d},
               {frame_valid, sync_err, locked, slot});
    end
    @(negedge clk) rst_n = 1'b1;
    drive(4'h9, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({locked, slot} !== 3'b000) begin
      failures++; $display("FAIL reset_hunt got=%b expected=000", {locked, slot});
    end
  endtask

  task automatic test_hunt;
    int s0, f0;
    s0 = serr_cnt; f0 = fv_cnt;
    drive(4'hD, 1'b0, 1'b1, 1'b1);
    drive(4'h8, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({locked, slot, sync_err} !== 4'b0000) begin
      failures++; $display("FAIL hunt_drop got=%b expected=0000", {locked, slot, sync_err});
    end
    drive(4'hF, 1'b1, 1'b1, 1'b1);
    drive(4'hA, 1'b0, 1'b1, 1'b1);
    drive(4'h6, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(16'hFA6F);
    drive(4'hF, 1'b0, 1'b1, 1'b1);
    idle(2);
    checks++;
    if ({fv_cnt - f0, serr_cnt - s0} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL hunt_counts got fv=%0d serr=%0d expected fv=1 serr=0", fv_cnt - f0, serr_cnt - s0);
    end
  endtask

  task automatic test_misalign;
    int s0, f0;
    s0 = serr_cnt; f0 = fv_cnt;
    drive(4'h3, 1'b1, 1'b1, 1'b1);
    drive(4'hE, 1'b0, 1'b1, 1'b1);
    drive(4'h9, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({sync_err, slot, out_a, out_b, out_c, out_d} !== {1'b1, 2'd1, 16'hFA6F}) begin
      failures++;
      $display("FAIL misalign_err got=%b/%0d/%h expected=1/1/fa6f", sync_err, slot, {out_a, out_b, out_c, out_d});
    end
    drive(4'h3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (sync_err !== 1'b0) begin
      failures++; $display("FAIL misalign_err_width got=%b expected=0", sync_err);
    end
    drive(4'hC, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(16'h93CE);
    drive(4'hE, 1'b0, 1'b1, 1'b1);
    idle(2);
    checks++;
    if ({fv_cnt - f0, serr_cnt - s0} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL misalign_counts got fv=%0d serr=%0d expected fv=1 serr=1", fv_cnt - f0, serr_cnt - s0);
    end
  endtask

  task automatic test_gaps_enable;
    int s0, f0;
    s0 = serr_cnt; f0 = fv_cnt;
    drive(4'hB, 1'b1, 1'b1, 1'b1);
    idle(1);
    drive(4'h7, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(4'h1 + 4'(i), 1'b1, 1'b1, 1'b0);
      checks++;
      if ({slot, frame_valid, sync_err, locked} !== {2'd2, 3'b001}) begin
        failures++; $display("FAIL enable_hold got=%b expected=10001", {slot, frame_valid, sync_err, locked});
      end
    end
    drive(4'h5, 1'b0, 1'b1, 1'b1);
    idle(1);
    exp_q.push_back(16'hB759);
    drive(4'h9, 1'b0, 1'b1, 1'b1);
    idle(2);
    checks++;
    if ({fv_cnt - f0, serr_cnt - s0} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL gaps_counts got fv=%0d serr=%0d expected fv=1 serr=0", fv_cnt - f0, serr_cnt - s0);
    end
  endtask

  task automatic test_wrap;
    int s0, f0;
    logic [4*W-1:0] frame;
    s0 = serr_cnt; f0 = fv_cnt;
    for (int f = 0; f < 3; f++) begin
      frame = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back(frame);
        drive(frame[4*W-1-4*k -: W], (f == 0 && k == 0), 1'b1, 1'b1);
        checks++;
        if (slot !== 2'(k + 1)) begin
          failures++; $display("FAIL wrap_slot got=%0d expected=%0d", slot, (k + 1) % 4);
        end
        if (f == 1 && k == 1) drive(4'hF, 1'b1, 1'b0, 1'b1);
      end
    end
    idle(2);
    checks++;
    if ({fv_cnt - f0, serr_cnt - s0} !== {32'd3, 32'd0}) begin
      failures++; $display("FAIL wrap_counts got fv=%0d serr=%0d expected fv=3 serr=0", fv_cnt - f0, serr_cnt - s0);
    end
  endtask

  task automatic test_drain;
    idle(3);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    test_power_on;
    test_nominal;
    test_reset;
    test_hunt;
    test_misalign;
    test_gaps_enable;
    test_wrap;
    test_drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
